// File: rtl/fetch_register_pkg.sv
// ============================================================================
// Module  : fetch_register_pkg
// Brief   : Shared constants and state encoding for the fetch/decode register.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_register_pkg;

    localparam logic [31:0] NOP_INSTR = 32'hD503201F;
    localparam logic [4:0]  XZR_INDEX = 5'd31;

    localparam int RN_LSB = 5;
    localparam int RN_MSB = 9;
    localparam int RM_LSB = 16;
    localparam int RM_MSB = 20;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/D_FF_enable.sv
// ============================================================================
// Module  : D_FF_enable
// Brief   : Single storage bit with load enable; reset is folded into d/en.
// Revision: 1.0
// ============================================================================
`default_nettype none

module D_FF_enable (
    input  logic clk,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (en) begin
            q <= d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_detect.sv
// ============================================================================
// Module  : hazard_detect
// Brief   : Combinational load-use hazard check between decode and execute.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_detect
    import fetch_register_pkg::*;
(
    input  logic       valid,
    input  logic [4:0] rn,
    input  logic [4:0] rm,
    input  logic       mem_to_reg,
    input  logic       reg_write,
    input  logic [4:0] rd,
    output logic       hazard
);

    logic w_src_match;

    // XZR is never a real producer, so it can never cause a dependency.
    assign w_src_match = (rd == rn) | (rd == rm);
    assign hazard      = valid & mem_to_reg & reg_write & (rd != XZR_INDEX) & w_src_match;

endmodule

`default_nettype wire

// File: rtl/fetch_register.sv
// ============================================================================
// Module  : fetch_register
// Brief   : IF/ID pipeline register with load-use stall and branch flush.
//           Optional perf counters enabled by FETCH_REGISTER_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_register
    import fetch_register_pkg::*;
#(
    parameter int LOAD_USE_STALL = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] PC_Fetch,
    input  logic [31:0] Instruction_Fetch,
    input  logic        flush_Fetch,
    input  logic        MemToReg_DecodeRegister,
    input  logic        RegWrite_DecodeRegister,
    input  logic [4:0]  Rd_DecodeRegister,
    output logic [63:0] PC_FetchRegister,
    output logic [31:0] Instruction_FetchRegister,
    output logic        valid_FetchRegister,
    output logic        stallPC,
    output logic        bubble_Decode
`ifdef FETCH_REGISTER_PERF_EN
    ,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
`endif
);

    localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALL - 1);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [1:0]   r_cnt;
    logic [1:0]   w_cnt_next;
    logic         w_hazard;
    logic         w_stall_cond;
    logic         w_en;
    logic [63:0]  w_pc_d;
    logic [31:0]  w_instr_d;
    logic         w_valid_d;
    logic [63:0]  r_pc;
    logic [31:0]  r_instr;
    logic         r_valid;

    hazard_detect u_hazard_detect (
        .valid      (r_valid),
        .rn         (r_instr[RN_MSB:RN_LSB]),
        .rm         (r_instr[RM_MSB:RM_LSB]),
        .mem_to_reg (MemToReg_DecodeRegister),
        .reg_write  (RegWrite_DecodeRegister),
        .rd         (Rd_DecodeRegister),
        .hazard     (w_hazard)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall_cond = 1'b0;
        case (r_state)
            RUN: begin
                if (w_hazard) begin
                    w_stall_cond = 1'b1;
                    w_state_next = STALL;
                    w_cnt_next   = STALL_INIT;
                end
            end
            STALL: begin
                // Final STALL cycle ignores the hazard so the pipeline always drains.
                if (r_cnt != 2'd0) begin
                    w_stall_cond = 1'b1;
                    w_cnt_next   = r_cnt - 2'd1;
                end else begin
                    w_state_next = RUN;
                    w_cnt_next   = 2'd0;
                end
            end
            default: begin
                w_state_next = RUN;
                w_cnt_next   = 2'd0;
            end
        endcase
        if (flush_Fetch) begin
            w_state_next = RUN;
            w_cnt_next   = 2'd0;
        end
        stallPC       = w_stall_cond & ~flush_Fetch;
        bubble_Decode = w_stall_cond | flush_Fetch;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Flush keeps the PC so the squashed slot still carries a meaningful address.
    assign w_en      = ~w_stall_cond | flush_Fetch | reset;
    assign w_pc_d    = reset ? 64'd0 : (flush_Fetch ? r_pc : PC_Fetch);
    assign w_instr_d = (reset | flush_Fetch) ? NOP_INSTR : Instruction_Fetch;
    assign w_valid_d = ~(reset | flush_Fetch);

    for (genvar i = 0; i < 64; i++) begin : g_pc_bits
        D_FF_enable u_ff (.clk(clk), .en(w_en), .d(w_pc_d[i]), .q(r_pc[i]));
    end

    for (genvar i = 0; i < 32; i++) begin : g_instr_bits
        D_FF_enable u_ff (.clk(clk), .en(w_en), .d(w_instr_d[i]), .q(r_instr[i]));
    end

    D_FF_enable u_valid_ff (.clk(clk), .en(w_en), .d(w_valid_d), .q(r_valid));

    assign PC_FetchRegister          = r_pc;
    assign Instruction_FetchRegister = r_instr;
    assign valid_FetchRegister       = r_valid;

`ifdef FETCH_REGISTER_PERF_EN
    logic [31:0] r_stall_count;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_count <= 32'd0;
            r_flush_count <= 32'd0;
        end else begin
            if (stallPC && (r_stall_count != 32'hFFFFFFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
            if (flush_Fetch && (r_flush_count != 32'hFFFFFFFF)) begin
                r_flush_count <= r_flush_count + 32'd1;
            end
        end
    end

    assign stallCount = r_stall_count;
    assign flushCount = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_register.sv
// ============================================================================
// Module  : tb_fetch_register
// Brief   : Directed bench for fetch_register (LOAD_USE_STALL = 1 and 3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_register;

    localparam logic [31:0] NOP  = 32'hD503201F;
    localparam logic [31:0] ADD1 = 32'h8B030041; // ADD X1,X2,X3
    localparam logic [31:0] ADD6 = 32'h8B0700A6; // ADD X6,X5,X7
    localparam logic [31:0] I3   = 32'h8B0300E8; // ADD X8,X7,X3
    localparam logic [31:0] I5   = 32'h8B0303E9; // ADD X9,XZR,X3

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] PC_Fetch;
    logic [31:0] Instruction_Fetch;
    logic        flush_Fetch;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  rd;

    logic [63:0] a_pc, b_pc;
    logic [31:0] a_ins, b_ins;
    logic        a_v, b_v, a_st, b_st, a_bu, b_bu;
`ifdef FETCH_REGISTER_PERF_EN
    logic [31:0] a_sc, a_fc, b_sc, b_fc;
`endif

    int passed = 0;
    int total  = 0;
    int n;

    always #5 clk = ~clk;

    fetch_register #(.LOAD_USE_STALL(1)) dut1 (
        .clk(clk), .reset(reset), .PC_Fetch(PC_Fetch), .Instruction_Fetch(Instruction_Fetch),
        .flush_Fetch(flush_Fetch), .MemToReg_DecodeRegister(mem_to_reg),
        .RegWrite_DecodeRegister(reg_write), .Rd_DecodeRegister(rd),
        .PC_FetchRegister(a_pc), .Instruction_FetchRegister(a_ins),
        .valid_FetchRegister(a_v), .stallPC(a_st), .bubble_Decode(a_bu)
`ifdef FETCH_REGISTER_PERF_EN
        , .stallCount(a_sc), .flushCount(a_fc)
`endif
    );

    fetch_register #(.LOAD_USE_STALL(3)) dut3 (
        .clk(clk), .reset(reset), .PC_Fetch(PC_Fetch), .Instruction_Fetch(Instruction_Fetch),
        .flush_Fetch(flush_Fetch), .MemToReg_DecodeRegister(mem_to_reg),
        .RegWrite_DecodeRegister(reg_write), .Rd_DecodeRegister(rd),
        .PC_FetchRegister(b_pc), .Instruction_FetchRegister(b_ins),
        .valid_FetchRegister(b_v), .stallPC(b_st), .bubble_Decode(b_bu)
`ifdef FETCH_REGISTER_PERF_EN
        , .stallCount(b_sc), .flushCount(b_fc)
`endif
    );

    typedef struct {
        logic        rst;
        logic        fl;
        logic [63:0] pc;
        logic [31:0] ins;
        logic        m;
        logic        w;
        logic [4:0]  rd;
        logic [63:0] e_pc;
        logic [31:0] e_ins;
        logic        e_v;
        logic        e_st;
        logic        e_bu;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic f, input logic [63:0] pc,
                         input logic [31:0] ins, input logic m, input logic w,
                         input logic [4:0] d);
        @(negedge clk);
        reset = r; flush_Fetch = f; PC_Fetch = pc; Instruction_Fetch = ins;
        mem_to_reg = m; reg_write = w; rd = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b1, 1'b0, 64'h00, 32'h0, 1'b0, 1'b0, 5'd0,  64'h00, NOP,  1'b0, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 64'h10, ADD1,  1'b0, 1'b0, 5'd0,  64'h10, ADD1, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 64'h14, ADD6,  1'b1, 1'b1, 5'd5,  64'h14, ADD6, 1'b1, 1'b1, 1'b1};
        vt[3]  = '{1'b0, 1'b0, 64'h18, I3,    1'b1, 1'b1, 5'd5,  64'h14, ADD6, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 64'h18, I3,    1'b0, 1'b0, 5'd0,  64'h18, I3,   1'b1, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 64'h1C, I5,    1'b1, 1'b1, 5'd31, 64'h1C, I5,   1'b1, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 64'h20, ADD6,  1'b1, 1'b1, 5'd31, 64'h20, ADD6, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 64'h24, ADD6,  1'b0, 1'b1, 5'd5,  64'h24, ADD6, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 64'h28, ADD1,  1'b1, 1'b1, 5'd3,  64'h28, ADD1, 1'b1, 1'b1, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 64'h2C, I3,    1'b1, 1'b1, 5'd3,  64'h28, NOP,  1'b0, 1'b0, 1'b1};
        vt[10] = '{1'b0, 1'b0, 64'h30, ADD6,  1'b0, 1'b0, 5'd0,  64'h30, ADD6, 1'b1, 1'b0, 1'b0};
        vt[11] = '{1'b1, 1'b0, 64'h34, ADD6,  1'b1, 1'b1, 5'd3,  64'h00, NOP,  1'b0, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b0, 64'h40, ADD1,  1'b0, 1'b0, 5'd0,  64'h40, ADD1, 1'b1, 1'b0, 1'b0};
        vt[13] = '{1'b1, 1'b1, 64'h44, ADD1,  1'b0, 1'b0, 5'd0,  64'h00, NOP,  1'b0, 1'b0, 1'b1};
        vt[14] = '{1'b0, 1'b0, 64'h48, ADD1,  1'b0, 1'b0, 5'd0,  64'h48, ADD1, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; flush_Fetch = 1'b0; PC_Fetch = '0; Instruction_Fetch = '0;
        mem_to_reg = 1'b0; reg_write = 1'b0; rd = '0;

        for (int i = 0; i < 15; i++) begin
            drive(vt[i].rst, vt[i].fl, vt[i].pc, vt[i].ins, vt[i].m, vt[i].w, vt[i].rd);
            tick();
            check($sformatf("v%0d_pc", i),    a_pc,         vt[i].e_pc);
            check($sformatf("v%0d_ins", i),   64'(a_ins),   64'(vt[i].e_ins));
            check($sformatf("v%0d_valid", i), 64'(a_v),     64'(vt[i].e_v));
            check($sformatf("v%0d_stall", i), 64'(a_st),    64'(vt[i].e_st));
            check($sformatf("v%0d_bubble", i), 64'(a_bu),   64'(vt[i].e_bu));
        end

        // Three-cycle stall on the LOAD_USE_STALL=3 instance.
        drive(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 5'd0); tick();
        drive(1'b0, 1'b0, 64'h100, ADD6, 1'b1, 1'b1, 5'd5); tick();
        check("s3_first_stall", 64'(b_st), 64'd1);
        drive(1'b0, 1'b0, 64'h104, I3, 1'b1, 1'b1, 5'd5);
        n = 1;
        for (int k = 0; k < 8 && b_st; k++) begin
            tick();
            if (b_st) n++;
        end
        check("s3_stall_cycles", 64'(n), 64'd3);
        check("s3_pc_held", b_pc, 64'h100);
        check("s3_bubble_off", 64'(b_bu), 64'd0);
        tick();
        check("s3_pc_loaded", b_pc, 64'h104);
        check("s3_ins_loaded", 64'(b_ins), 64'(I3));
        check("s3_stall_after", 64'(b_st), 64'd0);
`ifdef FETCH_REGISTER_PERF_EN
        check("s3_stall_count", 64'(b_sc), 64'd3);
`endif

        // Reset in the second cycle of a 3-cycle stall.
        drive(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 5'd0); tick();
        drive(1'b0, 1'b0, 64'h200, ADD6, 1'b1, 1'b1, 5'd5); tick();
        check("rs_stall1", 64'(b_st), 64'd1);
        drive(1'b0, 1'b0, 64'h204, I3, 1'b1, 1'b1, 5'd5); tick();
        check("rs_stall2", 64'(b_st), 64'd1);
        drive(1'b1, 1'b0, 64'h208, I3, 1'b1, 1'b1, 5'd5); tick();
        check("rs_pc", b_pc, 64'h0);
        check("rs_ins", 64'(b_ins), 64'(NOP));
        check("rs_valid", 64'(b_v), 64'd0);
        check("rs_stall", 64'(b_st), 64'd0);
        check("rs_bubble", 64'(b_bu), 64'd0);
        drive(1'b0, 1'b0, 64'h20C, I3, 1'b0, 1'b0, 5'd0); tick();
        check("rs_run_load", b_pc, 64'h20C);

        // Flush while in STALL.
        drive(1'b1, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 5'd0); tick();
        drive(1'b0, 1'b0, 64'h300, ADD6, 1'b1, 1'b1, 5'd5); tick();
        drive(1'b0, 1'b0, 64'h304, I3, 1'b1, 1'b1, 5'd5); tick();
        check("fl_in_stall", 64'(b_st), 64'd1);
        @(negedge clk);
        flush_Fetch = 1'b1;
        #1;
        check("fl_cycle_stall", 64'(b_st), 64'd0);
        check("fl_cycle_bubble", 64'(b_bu), 64'd1);
        tick();
        check("fl_ins", 64'(b_ins), 64'(NOP));
        check("fl_valid", 64'(b_v), 64'd0);
        check("fl_pc", b_pc, 64'h300);
`ifdef FETCH_REGISTER_PERF_EN
        check("fl_flush_count", 64'(b_fc), 64'd1);
`endif
        drive(1'b0, 1'b0, 64'h308, I3, 1'b1, 1'b1, 5'd5);
        #1;
        check("fl_after_stall", 64'(b_st), 64'd0);
        check("fl_after_bubble", 64'(b_bu), 64'd0);
        tick();
        check("fl_run_load", b_pc, 64'h308);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_register.md
FETCH_REGISTER -- requirements
Module: fetch_register

Interface
REQ-001 Parameter: LOAD_USE_STALL, default 1, number of stall cycles inserted per load-use hazard; legal range 1..3.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: PC_Fetch  input  64  PC of the fetched instruction.
REQ-005 Port: Instruction_Fetch  input  32  fetched instruction word.
REQ-006 Port: flush_Fetch  input  1  branch taken in execute; discard the held instruction.
REQ-007 Port: MemToReg_DecodeRegister, RegWrite_DecodeRegister  input  1 each  control bits of the instruction currently in execute.
REQ-008 Port: Rd_DecodeRegister  input  5  destination register of the instruction currently in execute.
REQ-009 Port: PC_FetchRegister  output  64  registered PC presented to decode.
REQ-010 Port: Instruction_FetchRegister  output  32  registered instruction presented to decode.
REQ-011 Port: valid_FetchRegister  output  1  the held instruction is live.
REQ-012 Port: stallPC  output  1  hold the PC register this cycle.
REQ-013 Port: bubble_Decode  output  1  force all decode control outputs to 0 this cycle.

Function
REQ-014 Source fields of the held instruction: Rn = Instruction_FetchRegister[9:5] and Rm = Instruction_FetchRegister[20:16].
REQ-015 hazard = valid_FetchRegister & MemToReg_DecodeRegister & RegWrite_DecodeRegister & (Rd_DecodeRegister != 31) & (Rd_DecodeRegister == Rn | Rd_DecodeRegister == Rm); hazard is combinational.
REQ-016 FSM states are RUN and STALL, with a 2-bit stall counter.
REQ-017 In RUN with no hazard, each edge loads PC_Fetch, Instruction_Fetch and valid=1; stallPC=0 and bubble_Decode=0.
REQ-018 In RUN with hazard, stallPC=1 and bubble_Decode=1 in the same cycle; registers hold; at the edge go to STALL with counter=LOAD_USE_STALL-1.
REQ-019 In STALL with counter != 0, stallPC=1, bubble_Decode=1 and registers hold; the counter decrements each edge.
REQ-020 In STALL with counter == 0, stallPC=0, bubble_Decode=0 and hazard is ignored; at the edge, load normally and return to RUN.
REQ-021 With LOAD_USE_STALL=1, the path is RUN→STALL(counter 0)→RUN: exactly one bubble per hazard.
REQ-022 Flush priority: flush_Fetch=1 overrides stall in any state; at the edge Instruction_FetchRegister=32'hD503201F (NOP), valid=0, PC unchanged, state=RUN, counter=0.
REQ-023 During a flush cycle, stallPC=0 and bubble_Decode=1.
REQ-024 Load-to-output latency is 1 cycle.
REQ-025 An invalid held instruction never raises a hazard.

Reset
REQ-026 While reset=1 at an edge: PC_FetchRegister=0, Instruction_FetchRegister=32'hD503201F, valid=0, state=RUN, counter=0 (and perf counters=0 when enabled).
REQ-027 A reset asserted mid-STALL aborts the stall at that edge; stallPC and bubble_Decode read 0 in the following cycle.
REQ-028 reset takes priority over flush_Fetch.

Configuration
REQ-029 With FETCH_REGISTER_PERF_EN defined, add outputs stallCount[31:0] and flushCount[31:0]: stallCount increments per cycle with stallPC=1; flushCount increments per flush edge; both saturate at 32'hFFFFFFFF.
REQ-030 Without FETCH_REGISTER_PERF_EN, those ports and counters are absent; all other behaviour is identical.

Structure
REQ-031 A shared package holds NOP_INSTR (32'hD503201F), XZR_INDEX (31), the Rn/Rm field positions, and the RUN/STALL state enum.
REQ-032 Storage bits use the D_FF_enable cell; enable = ~(stall condition) | flush | reset.
REQ-033 One sub-module, hazard_detect, computes hazard combinationally.

Verification
REQ-034 Reset, then load PC=0x10 with ADD X1,X2,X3; the next cycle shows PC_FetchRegister=0x10, valid=1, stallPC=0.
REQ-035 Hold LDUR X5 in execute (MemToReg=1, RegWrite=1, Rd=5) with ADD X6,X5,X7 in decode: one cycle of stallPC=1 and bubble_Decode=1, outputs held, then resume.
REQ-036 Same as REQ-035 but Rd=31 or valid=0: no stall.
REQ-037 flush_Fetch during STALL: next cycle shows instruction=NOP, valid=0, stallPC=0, state RUN.
REQ-038 LOAD_USE_STALL=3 with a hazard: exactly 3 stall cycles, then PC_Fetch is loaded; with perf enabled, stallCount=3.
REQ-039 Reset asserted in the second cycle of a 3-cycle stall: next cycle shows all reset values and stallPC=0.
